// File: rtl/sgm_path_cost_agg.sv
// Left-to-right SGM path-cost aggregation: one pixel per clock, 3-cycle latency, saturating Lr.
// Optional SGM_OVF_FLAG_EN adds a sticky saturation flag and a clamped-pixel counter.
module sgm_path_cost_agg #(
  parameter int unsigned COST_W   = 8,
  parameter int unsigned NUM_DISP = 16,
  parameter int unsigned P1       = 10,
  parameter int unsigned P2       = 120
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_sol,
  input  logic [NUM_DISP*COST_W-1:0]   in_cost,
  output logic                         out_valid,
  output logic                         out_sol,
  output logic [NUM_DISP*COST_W-1:0]   out_lr,
  output logic [COST_W-1:0]            out_min,
  output logic                         ovf_flag
);

  localparam int unsigned VEC_W = NUM_DISP * COST_W;
  localparam int unsigned IW    = COST_W + 2;
  localparam logic [IW-1:0] SAT_MAX = {2'b00, {COST_W{1'b1}}};
  localparam logic [IW-1:0] P1_I    = IW'(P1);
  localparam logic [IW-1:0] P2_I    = IW'(P2);

  logic              s1_valid, s1_sol;
  logic [VEC_W-1:0]  s1_cost;
  logic              s2_valid, s2_sol;
  logic [VEC_W-1:0]  lp_q;
  logic [COST_W-1:0] mp_q;

  logic [VEC_W-1:0]  lr_nxt;
  logic [COST_W-1:0] min_nxt;
  logic [IW-1:0]     nb_ext [NUM_DISP+2];
`ifdef SGM_OVF_FLAG_EN
  logic              clamp_c;
`endif

  // Neighbour candidates Lp[k-1]+P1, padded with all-ones at both ends so edge disparities never pick them
  always_comb begin
    for (int unsigned k = 0; k < NUM_DISP + 2; k++) nb_ext[k] = '1;
    for (int unsigned k = 1; k <= NUM_DISP; k++)
      nb_ext[k] = IW'(lp_q[(k-1)*COST_W +: COST_W]) + P1_I;
  end

  // Stage 2 recurrence, saturation and minimum
  always_comb begin
    logic [IW-1:0] c_i, m_i, sum_i, mp_i;
    logic [COST_W-1:0] lr_d;
    lr_nxt  = '0;
    min_nxt = '1;
    c_i     = '0;
    m_i     = '0;
    sum_i   = '0;
    lr_d    = '0;
    mp_i    = IW'(mp_q);
`ifdef SGM_OVF_FLAG_EN
    clamp_c = 1'b0;
`endif
    for (int unsigned d = 0; d < NUM_DISP; d++) begin
      c_i = IW'(s1_cost[d*COST_W +: COST_W]);
      m_i = IW'(lp_q[d*COST_W +: COST_W]);
      if (nb_ext[d] < m_i)     m_i = nb_ext[d];
      if (nb_ext[d+2] < m_i)   m_i = nb_ext[d+2];
      if (mp_i + P2_I < m_i)   m_i = mp_i + P2_I;
      sum_i = c_i + m_i - mp_i;
      if (s1_sol) begin
        lr_d = s1_cost[d*COST_W +: COST_W];
      end else if (sum_i > SAT_MAX) begin
        lr_d = '1;
`ifdef SGM_OVF_FLAG_EN
        clamp_c = 1'b1;
`endif
      end else begin
        lr_d = COST_W'(sum_i);
      end
      lr_nxt[d*COST_W +: COST_W] = lr_d;
      if (lr_d < min_nxt) min_nxt = lr_d;
    end
  end

  // Stage 1 input register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sol   <= 1'b0;
      s1_cost  <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_sol   <= in_sol & in_valid;
      s1_cost  <= in_cost;
    end
  end

  // Stage 2 state doubles as the recurrence memory; held across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sol   <= 1'b0;
      lp_q     <= '0;
      mp_q     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sol <= s1_sol;
        lp_q   <= lr_nxt;
        mp_q   <= min_nxt;
      end
    end
  end

  // Stage 3 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_lr    <= '0;
      out_min   <= '0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sol <= s2_sol;
        out_lr  <= lp_q;
        out_min <= mp_q;
      end
    end
  end

`ifdef SGM_OVF_FLAG_EN
  logic [15:0] clamp_cnt;

  // Sticky flag plus saturating clamped-pixel count for debug
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag  <= 1'b0;
      clamp_cnt <= '0;
    end else if (s1_valid && clamp_c) begin
      ovf_flag <= 1'b1;
      if (clamp_cnt != 16'hFFFF) clamp_cnt <= clamp_cnt + 16'd1;
    end
  end
`else
  assign ovf_flag = 1'b0;
`endif

endmodule

// File: tb/tb_sgm_path_cost_agg.sv
// Table-driven bench for sgm_path_cost_agg (NUM_DISP=4) with an expected-output queue.
module tb_sgm_path_cost_agg;

  localparam int unsigned CW = 8;
  localparam int unsigned ND = 4;
  localparam int unsigned VW = CW * ND;
`ifdef SGM_OVF_FLAG_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_sol;
  logic [VW-1:0] in_cost;
  logic          out_valid, out_sol;
  logic [VW-1:0] out_lr;
  logic [CW-1:0] out_min;
  logic          ovf_flag;

  sgm_path_cost_agg #(.COST_W(CW), .NUM_DISP(ND), .P1(10), .P2(120)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sol(in_sol), .in_cost(in_cost),
    .out_valid(out_valid), .out_sol(out_sol), .out_lr(out_lr), .out_min(out_min),
    .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sol;
    logic [VW-1:0] cost;
    logic [VW-1:0] lr;
    logic [CW-1:0] mn;
    int            gap;
    int            spacing;
    logic          clamps;
  } vec_t;

  typedef struct {
    logic          sol;
    logic [VW-1:0] lr;
    logic [CW-1:0] mn;
    int            spacing;
    logic          clamps;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0, n_total = 0, n_out = 0;
  int   cyc = 0, last_out_cyc = 0;
  logic sticky = 1'b0;

  function automatic logic [VW-1:0] pk(input int d0, input int d1, input int d2, input int d3);
    return {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
  endfunction

  function automatic void chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pop the scoreboard on every valid output
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      n_out++;
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: out_valid=1 with no pending pixel (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("out_lr", out_lr, e.lr);
        chk("out_min", VW'(out_min), VW'(e.mn));
        chk("out_sol", VW'(out_sol), VW'(e.sol));
        if (e.spacing > 0) chk("out_spacing", VW'(cyc - last_out_cyc), VW'(e.spacing));
        if (e.clamps) sticky = OVF_EN;
        chk("ovf_flag", VW'(ovf_flag), VW'(sticky));
      end
      last_out_cyc = cyc;
    end
  end

  task automatic drive(input logic v, input logic s, input logic [VW-1:0] c);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sol   = s;
    in_cost  = c;
  endtask

  task automatic idle_random_sol();
    drive(1'b0, 1'b1, VW'({$urandom, $urandom}));
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d pixels still pending", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  vec_t vt[7];

  initial begin
    int   out_before;
    exp_t e;

    vt[0] = '{1'b1, pk(5,3,7,9),       pk(5,3,7,9),       8'd3, 0, 0, 1'b0};
    vt[1] = '{1'b0, pk(0,0,0,0),       pk(2,0,4,6),       8'd0, 0, 1, 1'b0};
    vt[2] = '{1'b0, pk(1,1,1,1),       pk(3,1,5,7),       8'd1, 0, 1, 1'b0};
    vt[3] = '{1'b1, pk(0,200,200,200), pk(0,200,200,200), 8'd0, 0, 1, 1'b0};
    vt[4] = '{1'b0, pk(0,250,250,250), pk(0,255,255,255), 8'd0, 0, 1, 1'b1};
    vt[5] = '{1'b1, pk(5,3,7,9),       pk(5,3,7,9),       8'd3, 0, 1, 1'b0};
    vt[6] = '{1'b0, pk(0,0,0,0),       pk(2,0,4,6),       8'd0, 3, 4, 1'b0};

    // Reset held with random inputs
    rst_n = 1'b0; in_valid = 1'b0; in_sol = 1'b0; in_cost = '0;
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), 1'($urandom), VW'({$urandom, $urandom}));
      @(negedge clk);
      chk("rst_out_valid", VW'(out_valid), '0);
      chk("rst_out_lr", out_lr, '0);
      chk("rst_out_min", VW'(out_min), '0);
      chk("rst_ovf", VW'(ovf_flag), '0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; in_sol = 1'b0; in_cost = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_out_valid", VW'(out_valid), '0);
    chk("idle_out_lr", out_lr, '0);
    chk("idle_out_min", VW'(out_min), '0);

    // Vector table; idle gaps carry in_sol=1 with in_valid=0, which must be ignored
    for (int i = 0; i < 7; i++) begin
      for (int g = 0; g < vt[i].gap; g++) idle_random_sol();
      e = '{vt[i].sol, vt[i].lr, vt[i].mn, vt[i].spacing, vt[i].clamps};
      sbq.push_back(e);
      drive(1'b1, vt[i].sol, vt[i].cost);
    end
    drive(1'b0, 1'b0, '0);
    drain(20);
    chk("ovf_after_sat", VW'(ovf_flag), VW'(OVF_EN));

    // Mid-line reset with two pixels in flight
    out_before = n_out;
    drive(1'b1, 1'b1, pk(5,3,7,9));
    drive(1'b1, 1'b0, pk(1,1,1,1));
    drive(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    sticky = 1'b0;
    #1;
    chk("midrst_out_valid", VW'(out_valid), '0);
    chk("midrst_ovf", VW'(ovf_flag), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("midrst_lost_pixels", VW'(n_out - out_before), '0);
    e = '{1'b0, pk(0,0,0,0), 8'd0, 0, 1'b0};
    sbq.push_back(e);
    drive(1'b1, 1'b0, pk(0,0,0,0));
    drive(1'b0, 1'b0, '0);
    drain(20);
    chk("final_out_count", VW'(n_out - out_before), VW'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
